inst_fetch_unit: RTL

//  Read-side client of the instruction memory. Keeps the PC and drives the memory

---
 rtl/inst_fetch_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC keeper and instruction-memory read client feeding decode through a
// 2-entry valid/ready buffer with redirect/flush. Define IFETCH_BYPASS_EN for same-cycle bypass.
module inst_fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_dataout,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;

    // Two-entry FIFO kept as explicit head/tail slots; the head slot drives decode.
    logic              head_valid, tail_valid;
    logic [ADDR_W-1:0] head_pc, tail_pc;
    logic [DATA_W-1:0] head_instr, tail_instr;

    logic              n_head_valid, n_tail_valid;
    logic [ADDR_W-1:0] n_head_pc, n_tail_pc;
    logic [DATA_W-1:0] n_head_instr, n_tail_instr;

    logic       capture;
    logic       bypass;
    logic       pop;
    logic       head_pop;
    logic       push;
    logic       issue;
    logic [2:0] occupancy;

    // Returning data is dropped in a redirect cycle: it belongs to the old stream.
    assign capture = inflight & ~redirect_valid;

`ifdef IFETCH_BYPASS_EN
    assign bypass    = capture & ~head_valid;
    assign out_valid = head_valid | bypass;
    assign out_pc    = bypass ? inflight_pc  : head_pc;
    assign out_instr = bypass ? imem_dataout : head_instr;
`else
    assign bypass    = 1'b0;
    assign out_valid = head_valid;
    assign out_pc    = head_pc;
    assign out_instr = head_instr;
`endif

    assign pop      = out_valid & out_ready;
    assign head_pop = head_valid & out_ready;
    // A bypassed word accepted by decode this cycle never enters the buffer.
    assign push     = capture & ~(bypass & out_ready);

    // Words buffered plus the one in flight, less the one leaving; never exceeds 2.
    assign occupancy = 3'(head_valid) + 3'(tail_valid) + 3'(inflight) - 3'(pop);
    assign issue     = ~redirect_valid & (occupancy < 3'd2);

    assign imem_addr = pc;

    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer latches.
    always_comb begin
        n_head_valid = head_valid;
        n_head_pc    = head_pc;
        n_head_instr = head_instr;
        n_tail_valid = tail_valid;
        n_tail_pc    = tail_pc;
        n_tail_instr = tail_instr;

        if (head_pop) begin
            n_head_valid = tail_valid;
            n_head_pc    = tail_pc;
            n_head_instr = tail_instr;
            n_tail_valid = 1'b0;
        end

        if (push) begin
            if (!n_head_valid) begin
                n_head_valid = 1'b1;
                n_head_pc    = inflight_pc;
                n_head_instr = imem_dataout;
            end else begin
                n_tail_valid = 1'b1;
                n_tail_pc    = inflight_pc;
                n_tail_instr = imem_dataout;
            end
        end

        // The pop above still completes; whatever remains is flushed.
        if (redirect_valid) begin
            n_head_valid = 1'b0;
            n_tail_valid = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= START_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            // NOTE: the buffer slots are reset (not just their valid bits) because the
            // head slot drives out_pc/out_instr, which must read zero after reset.
            head_valid  <= 1'b0;
            head_pc     <= '0;
            head_instr  <= '0;
            tail_valid  <= 1'b0;
            tail_pc     <= '0;
            tail_instr  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end

            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc <= pc + ADDR_W'(1);
            end

            head_valid <= n_head_valid;
            head_pc    <= n_head_pc;
            head_instr <= n_head_instr;
            tail_valid <= n_tail_valid;
            tail_pc    <= n_tail_pc;
            tail_instr <= n_tail_instr;
        end
    end

endmodule
